// File: rtl/ceres_rst_seq.sv
// ceres_rst_seq: reset / clock-status sequencer for the SoC top.
//   Qualifies PLL lock (synchroniser + consecutive-sample filter), merges
//   PLL-loss, watchdog and software reset requests, and releases
//   NUM_DOMAINS active-low domain resets one after another (bit 0 first).
//   A sticky cause register records why the last reset happened.
//
// Ports:
//   clk_i          in   system clock (PLL output)
//   rst_ni         in   asynchronous active-low reset
//   pll_locked_i   in   PLL lock, asynchronous to clk_i
//   wdt_reset_i    in   watchdog reset request (synchronous, level or pulse)
//   sw_reset_i     in   software reset request (synchronous, level or pulse)
//   cause_clr_i    in   clear sticky cause bits (synchronous pulse)
//   rst_domain_no  out  per-domain active-low resets, bit 0 released first
//   rst_done_o     out  high once every domain is released
//   state_o        out  FSM state: 0=HOLD 1=STRETCH 2=RELEASE 3=RUN
//   reset_cause_o  out  sticky cause: [0] power-on [1] lock loss [2] wdt [3] sw
module ceres_rst_seq #(
    parameter int NUM_DOMAINS    = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int LOCK_FILTER    = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   pll_locked_i,
    input  logic                   wdt_reset_i,
    input  logic                   sw_reset_i,
    input  logic                   cause_clr_i,
    output logic [NUM_DOMAINS-1:0] rst_domain_no,
    output logic                   rst_done_o,
    output logic [1:0]             state_o,
    output logic [3:0]             reset_cause_o
);

    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int SW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam int GW = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
    localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [FW-1:0] FILT_MAX = FW'(LOCK_FILTER);
    localparam logic [SW-1:0] STR_LAST = SW'(STRETCH_CYCLES - 1);
    localparam logic [GW-1:0] STG_LAST = GW'(STAGGER_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_STRETCH = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FW-1:0]          r_filt;
    state_t                 r_state;
    logic [SW-1:0]          r_str_cnt;
    logic [GW-1:0]          r_stg_cnt;
    logic [IW-1:0]          r_idx;
    logic [NUM_DOMAINS-1:0] r_dom;
    logic                   r_done;
    logic [3:0]             r_cause;

    logic                   w_lock_s;
    logic                   w_lock_q;
    logic                   w_lock_loss;
    logic                   w_req;
    logic [FW-1:0]          w_filt_nxt;
    state_t                 w_state_nxt;
    logic [SW-1:0]          w_str_cnt_nxt;
    logic [GW-1:0]          w_stg_cnt_nxt;
    logic [IW-1:0]          w_idx_nxt;
    logic [NUM_DOMAINS-1:0] w_dom_nxt;
    logic                   w_done_nxt;
    logic [3:0]             w_cause_nxt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync    <= '0;
            r_filt    <= '0;
            r_state   <= S_HOLD;
            r_str_cnt <= '0;
            r_stg_cnt <= '0;
            r_idx     <= '0;
            r_dom     <= '0;
            r_done    <= 1'b0;
            r_cause   <= 4'b0001;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], pll_locked_i};
            r_filt    <= w_filt_nxt;
            r_state   <= w_state_nxt;
            r_str_cnt <= w_str_cnt_nxt;
            r_stg_cnt <= w_stg_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_dom     <= w_dom_nxt;
            r_done    <= w_done_nxt;
            r_cause   <= w_cause_nxt;
        end
    end

    always_comb begin
        w_lock_s = r_sync[SYNC_STAGES-1];

        if (!w_lock_s)
            w_filt_nxt = '0;
        else if (r_filt != FILT_MAX)
            w_filt_nxt = r_filt + FW'(1);
        else
            w_filt_nxt = r_filt;

        // Lock qualifies on the count being loaded this edge, so HOLD leaves
        // on the same edge the filter saturates (all terms are registered).
        w_lock_q    = (w_filt_nxt == FILT_MAX);
        w_lock_loss = !w_lock_s && (r_state != S_HOLD);
        w_req       = wdt_reset_i | sw_reset_i | w_lock_loss;

        w_state_nxt   = r_state;
        w_str_cnt_nxt = r_str_cnt;
        w_stg_cnt_nxt = r_stg_cnt;
        w_idx_nxt     = r_idx;
        w_dom_nxt     = r_dom;
        w_done_nxt    = r_done;

        if (w_req && (r_state != S_HOLD)) begin
            w_state_nxt   = S_HOLD;
            w_str_cnt_nxt = '0;
            w_stg_cnt_nxt = '0;
            w_idx_nxt     = '0;
            w_dom_nxt     = '0;
            w_done_nxt    = 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    w_dom_nxt  = '0;
                    w_done_nxt = 1'b0;
                    if (w_lock_q && !w_req) begin
                        w_state_nxt   = S_STRETCH;
                        w_str_cnt_nxt = '0;
                    end
                end
                S_STRETCH: begin
                    if (r_str_cnt == STR_LAST) begin
                        w_dom_nxt     = '0;
                        w_dom_nxt[0]  = 1'b1;
                        w_stg_cnt_nxt = '0;
                        w_idx_nxt     = IW'(1);
                        if (NUM_DOMAINS == 1) begin
                            w_state_nxt = S_RUN;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_RELEASE;
                        end
                    end else begin
                        w_str_cnt_nxt = r_str_cnt + SW'(1);
                    end
                end
                S_RELEASE: begin
                    if (r_stg_cnt == STG_LAST) begin
                        for (int unsigned d = 0; d < NUM_DOMAINS; d++) begin
                            if (r_idx == IW'(d))
                                w_dom_nxt[d] = 1'b1;
                        end
                        w_stg_cnt_nxt = '0;
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt = S_RUN;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + IW'(1);
                        end
                    end else begin
                        w_stg_cnt_nxt = r_stg_cnt + GW'(1);
                    end
                end
                S_RUN: begin
                    w_dom_nxt  = '1;
                    w_done_nxt = 1'b1;
                end
                default: w_state_nxt = S_HOLD;
            endcase
        end

        // A source asserted on the clearing edge survives; others clear.
        w_cause_nxt = (cause_clr_i ? 4'b0000 : r_cause) |
                      {sw_reset_i, wdt_reset_i, w_lock_loss, 1'b0};
    end

    assign rst_domain_no = r_dom;
    assign rst_done_o    = r_done;
    assign state_o       = r_state;
    assign reset_cause_o = r_cause;

endmodule

// File: tb/tb_ceres_rst_seq.sv
// Self-checking bench for ceres_rst_seq with default parameters.
module tb_ceres_rst_seq;

    logic       clk_i;
    logic       rst_ni;
    logic       pll_locked_i;
    logic       wdt_reset_i;
    logic       sw_reset_i;
    logic       cause_clr_i;
    logic [3:0] rst_domain_no;
    logic       rst_done_o;
    logic [1:0] state_o;
    logic [3:0] reset_cause_o;

    ceres_rst_seq #(
        .NUM_DOMAINS   (4),
        .SYNC_STAGES   (2),
        .LOCK_FILTER   (4),
        .STRETCH_CYCLES(16),
        .STAGGER_CYCLES(8)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .pll_locked_i (pll_locked_i),
        .wdt_reset_i  (wdt_reset_i),
        .sw_reset_i   (sw_reset_i),
        .cause_clr_i  (cause_clr_i),
        .rst_domain_no(rst_domain_no),
        .rst_done_o   (rst_done_o),
        .state_o      (state_o),
        .reset_cause_o(reset_cause_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        string      name;
        logic [3:0] dom;
        logic       done;
        logic [1:0] st;
        logic [3:0] cause;
    } exp_t;

    typedef struct {
        int         n;
        bit         pll;
        logic [3:0] dom;
        logic       done;
        logic [1:0] st;
    } po_vec_t;

    exp_t    exp_q[$];
    po_vec_t po_tab[11];
    int      errors = 0;
    int      checks = 0;

    task automatic compare_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got no expectation, want one queued");
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if ({rst_domain_no, rst_done_o, state_o, reset_cause_o} !==
            {e.dom, e.done, e.st, e.cause}) begin
            errors++;
            $display("FAIL %s: got dom=%b done=%b st=%0d cause=%b, want dom=%b done=%b st=%0d cause=%b",
                     e.name, rst_domain_no, rst_done_o, state_o, reset_cause_o,
                     e.dom, e.done, e.st, e.cause);
        end
    endtask

    task automatic tick(input bit pll, input bit wdt, input bit sw, input bit clr);
        pll_locked_i = pll;
        wdt_reset_i  = wdt;
        sw_reset_i   = sw;
        cause_clr_i  = clr;
        @(posedge clk_i);
        #1;
    endtask

    task automatic step_chk(input string nm, input bit pll, input bit wdt, input bit sw,
                            input bit clr, input logic [3:0] dom, input logic done,
                            input logic [1:0] st, input logic [3:0] cause);
        exp_q.push_back('{nm, dom, done, st, cause});
        tick(pll, wdt, sw, clr);
        compare_pop();
    endtask

    // Expected outputs t edges after STRETCH entry (t<0: still in HOLD).
    function automatic void exp_at(input int t, output logic [3:0] dom,
                                   output logic done, output logic [1:0] st);
        for (int k = 0; k < 4; k++) dom[k] = (t >= 16 + 8 * k);
        done = (t >= 40);
        if (t < 0)       st = 2'd0;
        else if (t < 16) st = 2'd1;
        else if (t < 40) st = 2'd2;
        else             st = 2'd3;
    endfunction

    task automatic run_seq(input string nm, input int t0, input int t1,
                           input logic [3:0] cause);
        logic [3:0] d;
        logic       dn;
        logic [1:0] s;
        for (int t = t0; t <= t1; t++) begin
            exp_at(t, d, dn, s);
            step_chk(nm, 1'b1, 1'b0, 1'b0, 1'b0, d, dn, s, cause);
        end
    endtask

    // Asserts rst_ni mid-cycle and checks the outputs before any clock edge.
    task automatic apply_reset(input bit pll_after);
        #2;
        rst_ni = 1'b0;
        #1;
        exp_q.push_back('{"async_rst", 4'b0000, 1'b0, 2'd0, 4'b0001});
        compare_pop();
        @(posedge clk_i);
        #1;
        exp_q.push_back('{"rst_hold", 4'b0000, 1'b0, 2'd0, 4'b0001});
        compare_pop();
        pll_locked_i = pll_after;
        wdt_reset_i  = 1'b0;
        sw_reset_i   = 1'b0;
        cause_clr_i  = 1'b0;
        #3;
        rst_ni = 1'b1;
    endtask

    initial begin
        int n;

        po_tab[0]  = '{5,  1'b1, 4'b0000, 1'b0, 2'd0};
        po_tab[1]  = '{6,  1'b1, 4'b0000, 1'b0, 2'd1};
        po_tab[2]  = '{21, 1'b1, 4'b0000, 1'b0, 2'd1};
        po_tab[3]  = '{22, 1'b1, 4'b0001, 1'b0, 2'd2};
        po_tab[4]  = '{29, 1'b1, 4'b0001, 1'b0, 2'd2};
        po_tab[5]  = '{30, 1'b1, 4'b0011, 1'b0, 2'd2};
        po_tab[6]  = '{37, 1'b1, 4'b0011, 1'b0, 2'd2};
        po_tab[7]  = '{38, 1'b1, 4'b0111, 1'b0, 2'd2};
        po_tab[8]  = '{45, 1'b1, 4'b0111, 1'b0, 2'd2};
        po_tab[9]  = '{46, 1'b1, 4'b1111, 1'b1, 2'd3};
        po_tab[10] = '{50, 1'b1, 4'b1111, 1'b1, 2'd3};

        rst_ni       = 1'b1;
        pll_locked_i = 1'b0;
        wdt_reset_i  = 1'b0;
        sw_reset_i   = 1'b0;
        cause_clr_i  = 1'b0;

        // Lock glitching 3 high / 1 low in HOLD never qualifies.
        apply_reset(1'b1);
        for (int i = 0; i < 40; i++)
            step_chk("glitch_hold", (i % 4) != 3, 1'b0, 1'b0, 1'b0,
                     4'b0000, 1'b0, 2'd0, 4'b0001);

        // Power-on with lock high from the first edge.
        apply_reset(1'b1);
        n = 0;
        foreach (po_tab[i]) begin
            while (n < po_tab[i].n - 1) begin
                tick(po_tab[i].pll, 1'b0, 1'b0, 1'b0);
                n++;
            end
            step_chk($sformatf("poweron_e%0d", po_tab[i].n), po_tab[i].pll, 1'b0, 1'b0,
                     1'b0, po_tab[i].dom, po_tab[i].done, po_tab[i].st, 4'b0001);
            n++;
        end

        // Software reset pulse in RUN, then full re-release.
        step_chk("sw_pulse", 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b1001);
        run_seq("sw_rerun", 0, 41, 4'b1001);

        // Watchdog and clear on the same edge; watchdog then held as a level.
        step_chk("wdt_clr", 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 4'b0100);
        for (int i = 0; i < 3; i++)
            step_chk("wdt_level_hold", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0100);
        run_seq("wdt_rerun", 0, 25, 4'b0100);

        // Lock lost while two domains are released.
        step_chk("lock_drop_e1", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b0, 2'd2, 4'b0100);
        step_chk("lock_drop_e2", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b0, 2'd2, 4'b0100);
        step_chk("lock_drop_e3", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0110);
        for (int i = 0; i < 4; i++)
            step_chk("lock_low_hold", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0110);
        run_seq("relock", -5, 5, 4'b0110);

        // Reset asserted mid-STRETCH.
        apply_reset(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ceres_rst_seq.md
Name: ceres_rst_seq

Overview:
- Parametrised reset/clock-status sequencer for the SoC top.
- Qualifies PLL lock and merges power-on, PLL-loss, watchdog and software reset requests.
- Releases NUM_DOMAINS synchronous active-low domain resets in a staggered order: interconnect first, then core, then peripherals.
- Keeps a sticky reset-cause register for firmware, and replaces raw rst_ni fan-out to the core wrapper.

Parameters:
- NUM_DOMAINS, 4: number of reset domain outputs, range 1..8.
- SYNC_STAGES, 2: synchroniser depth for pll_locked_i, minimum 2.
- LOCK_FILTER, 4: consecutive synced-high lock samples required, minimum 1.
- STRETCH_CYCLES, 16: cycles all domains stay asserted after lock qualifies, minimum 1.
- STAGGER_CYCLES, 8: cycles between successive domain releases, minimum 1.

Ports:
- clk_i, in, 1: system clock (PLL output).
- rst_ni, in, 1: async active-low reset.
- pll_locked_i, in, 1: PLL lock, asynchronous to clk_i.
- wdt_reset_i, in, 1: watchdog reset request, synchronous, level or pulse.
- sw_reset_i, in, 1: software reset request, synchronous, level or pulse.
- cause_clr_i, in, 1: clear sticky cause bits, synchronous pulse.
- rst_domain_no, out, NUM_DOMAINS: per-domain active-low reset; bit 0 is released first.
- rst_done_o, out, 1: high when all domains are released.
- state_o, out, 2: FSM state, 0=HOLD, 1=STRETCH, 2=RELEASE, 3=RUN.
- reset_cause_o, out, 4: sticky cause bits, [0]=power-on, [1]=PLL lock loss, [2]=watchdog, [3]=software.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low: rst_ni / clk_i.
- While rst_ni=0:
  - all flops reset, state=HOLD, rst_domain_no=0, rst_done_o=0.
  - reset_cause_o=4'b0001.
  - synchroniser flops 0, filter count 0.
- Lock synchroniser and filter:
  - pll_locked_i passes through SYNC_STAGES flops to give lock_s.
  - Filter counter increments while lock_s=1 and saturates at LOCK_FILTER; lock_q = (count==LOCK_FILTER).
  - Any lock_s=0 sample clears the counter the same edge.
- Reset request:
  - req = wdt_reset_i | sw_reset_i | (lock_s==0 and state!=HOLD).
  - All are registered decisions, with no combinational path to outputs.
- FSM:
  - HOLD:
    - all domains asserted.
    - go to STRETCH when lock_q=1 and req=0; the stretch counter loads 0.
  - STRETCH:
    - count STRETCH_CYCLES cycles.
    - on the last one go to RELEASE and deassert rst_domain_no[0] on that same edge.
    - stagger counter loads 0, domain index=1.
  - RELEASE:
    - every STAGGER_CYCLES cycles deassert the next domain bit.
    - the edge that deasserts bit NUM_DOMAINS-1 also enters RUN and sets rst_done_o=1.
    - NUM_DOMAINS=1: go STRETCH->RUN directly with bit 0 released.
  - RUN: hold all domains released, rst_done_o=1.
  - Any state except HOLD with req=1:
    - next edge go to HOLD.
    - all rst_domain_no bits = 0 and rst_done_o=0 on that same edge.
    - all counters cleared.
    - req has priority over every other transition.
  - HOLD with a sustained request: remain in HOLD until wdt_reset_i and sw_reset_i are both 0 and lock_q=1.
- Cause register:
  - on each req edge, OR in bits [1], [2], [3] per the active source; several bits may set in the same edge.
  - cause_clr_i clears all bits to 0.
  - if a set and cause_clr_i occur on the same edge, the set wins for that bit and the other bits clear.
- Latency with default parameters, counted from the first clk_i edge sampling pll_locked_i=1, lock held stable:
  - STRETCH entered after SYNC_STAGES+LOCK_FILTER = 6 edges.
  - rst_domain_no[0] releases at edge 22.
  - bit k releases at 22+8k.
  - rst_done_o=1 at edge 46.
- Lock glitch shorter than LOCK_FILTER while in HOLD: only restarts the filter, no cause bit set.
- rst_ni asserted mid-sequence: immediate async return to the reset values listed above.
- Domain bits only ever transition 0->1 in ascending index order and 1->0 all together.

Test Plan:
- Power-on, defaults, pll_locked_i high from cycle 0 -> rst_domain_no = 0000 until edge 22, then 0001@22, 0011@30, 0111@38, 1111@46; rst_done_o=1@46; reset_cause_o=0001.
- pll_locked_i toggles high 3 cycles, low 1, in a repeating pattern, while in HOLD -> state stays 0, rst_domain_no=0000, reset_cause_o unchanged.
- In RUN, 1-cycle sw_reset_i pulse -> next edge rst_domain_no=0000, state=0, reset_cause_o=1001. Lock steady, so re-release: STRETCH entered the edge after, full staggered sequence repeats, bit0 released 17 edges after the pulse.
- In RELEASE (rst_domain_no=0011), drop pll_locked_i -> after SYNC_STAGES edges all domains asserted, reset_cause_o[1]=1; sequence restarts only after lock is high for 6 edges.
- wdt_reset_i and cause_clr_i asserted in the same cycle in RUN, with cause=1001 beforehand -> reset_cause_o=0100, domains asserted.
- rst_ni pulsed low mid-STRETCH -> asynchronously state=0, rst_domain_no=0000, rst_done_o=0, reset_cause_o=0001, with no wait for a clock edge.
